// File: rtl/vga_pkg.sv
// Shared types and framebuffer geometry for the VGA display path.
package vga_pkg;

  localparam int unsigned H_RES    = 320;
  localparam int unsigned V_RES    = 200;
  localparam int unsigned FB_WORDS = H_RES * V_RES;

  typedef logic [11:0] pixel_t;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] w;
    logic [7:0] h;
    pixel_t     color;
  } fill_cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StFill,
    StDone
  } fill_state_t;

endpackage

// File: rtl/vga_fill_clip.sv
// Combinational clip of a fill rectangle against the framebuffer.
// Clipping is compiled in only when VGA_FILL_CLIP_EN is defined; otherwise w/h pass through.
module vga_fill_clip #(
  parameter int unsigned H_RES = 320,
  parameter int unsigned V_RES = 200
) (
  input  logic [8:0] x,
  input  logic [7:0] y,
  input  logic [8:0] w,
  input  logic [7:0] h,
  output logic [8:0] ew,
  output logic [7:0] eh
);

`ifdef VGA_FILL_CLIP_EN
  localparam logic [8:0] HMax = 9'(H_RES);
  localparam logic [7:0] VMax = 8'(V_RES);

  logic [8:0] room_x;
  logic [7:0] room_y;

  // Only meaningful when the origin is inside the buffer; the outer select covers the rest.
  assign room_x = HMax - x;
  assign room_y = VMax - y;

  assign ew = (x >= HMax) ? 9'd0 : ((w > room_x) ? room_x : w);
  assign eh = (y >= VMax) ? 8'd0 : ((h > room_y) ? room_y : h);
`else
  logic unused_xy;

  assign unused_xy = ^{x, y};
  assign ew        = w;
  assign eh        = h;
`endif

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: one pixel write per clock, raster order, into the linear framebuffer.
// Define VGA_FILL_CLIP_EN to clip rectangles to the framebuffer bounds.
module vga_rect_fill #(
  parameter int unsigned H_RES = 320,
  parameter int unsigned V_RES = 200
) (
  input  logic        main_clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [8:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [11:0] cmd_color,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        do_write,
  output logic [15:0] write_addr,
  output logic [11:0] write_data
);
  import vga_pkg::*;

  fill_state_t state_q;
  fill_cmd_t   cmd_in;
  fill_cmd_t   cmd_q;
  logic [8:0]  ew;
  logic [7:0]  eh;
  logic [8:0]  ew_q;
  logic [7:0]  eh_q;
  logic [15:0] base;
  logic [15:0] base_q;
  logic [8:0]  cx_q;
  logic [7:0]  ry_q;

  assign cmd_in = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color};
  assign busy   = ~cmd_ready;

  vga_fill_clip #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_clip (
    .x  (cmd_q.x),
    .y  (cmd_q.y),
    .w  (cmd_q.w),
    .h  (cmd_q.h),
    .ew (ew),
    .eh (eh)
  );

  // y*320 + x as shifts; wraps modulo 2^16 for out-of-range origins.
  assign base = {cmd_q.y, 8'b0} + {2'b0, cmd_q.y, 6'b0} + {7'b0, cmd_q.x};

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      ew_q       <= '0;
      eh_q       <= '0;
      base_q     <= '0;
      cx_q       <= '0;
      ry_q       <= '0;
      cmd_ready  <= 1'b1;
      done       <= 1'b0;
      do_write   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      done     <= 1'b0;
      do_write <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Ready stays low for the done cycle and rises on the edge after it.
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_q     <= cmd_in;
            cmd_ready <= 1'b0;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          if (abort) begin
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end else begin
            ew_q    <= ew;
            eh_q    <= eh;
            base_q  <= base;
            cx_q    <= '0;
            ry_q    <= '0;
            state_q <= (ew == 9'd0 || eh == 8'd0) ? StDone : StFill;
          end
        end
        StFill: begin
          if (abort) begin
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end else begin
            do_write   <= 1'b1;
            write_addr <= base_q + {7'b0, cx_q};
            write_data <= cmd_q.color;
            if (cx_q == ew_q - 9'd1) begin
              cx_q   <= '0;
              base_q <= base_q + 16'(H_RES);
              ry_q   <= ry_q + 8'd1;
              if (ry_q == eh_q - 8'd1) begin
                state_q <= StDone;
              end
            end else begin
              cx_q <= cx_q + 9'd1;
            end
          end
        end
        StDone: begin
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed self-checking bench for vga_rect_fill; covers clip or spill depending on VGA_FILL_CLIP_EN.
module tb_vga_rect_fill;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [11:0] cmd_color;
  logic        abort;
  logic        busy;
  logic        done;
  logic        do_write;
  logic [15:0] write_addr;
  logic [11:0] write_data;

  int cyc      = 0;
  int tests    = 0;
  int fails    = 0;
  int busy_err = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int done_cyc[$];
  int rdy_cyc[$];

  vga_rect_fill dut (
    .main_clk   (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_color  (cmd_color),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .do_write   (do_write),
    .write_addr (write_addr),
    .write_data (write_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Log every output event with the cycle it was observed in.
  initial begin
    logic prev_ready;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (do_write === 1'b1) begin
        wr_addr.push_back(int'(write_addr));
        wr_data.push_back(int'(write_data));
        wr_cyc.push_back(cyc);
      end
      if (done === 1'b1) done_cyc.push_back(cyc);
      if (cmd_ready === 1'b1 && prev_ready !== 1'b1) rdy_cyc.push_back(cyc);
      if (busy !== ~cmd_ready) busy_err++;
      prev_ready = cmd_ready;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    @(posedge clk);
    #1;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
    rdy_cyc.delete();
  endtask

  // Present a command and hold it until accepted; e0 is the cyc value at the accepting edge.
  task automatic send(input int x, input int y, input int w, input int h, input int color,
                      output int e0);
    int n;
    n  = 0;
    e0 = -1;
    while (e0 < 0 && n < 500) begin
      @(negedge clk);
      cmd_x     = 9'(x);
      cmd_y     = 8'(y);
      cmd_w     = 9'(w);
      cmd_h     = 8'(h);
      cmd_color = 12'(color);
      cmd_valid = 1'b1;
      if (cmd_ready === 1'b1) begin
        @(posedge clk);
        e0 = cyc;
      end
      n++;
    end
    if (e0 < 0) check("accept_timeout", 0, 1);
  endtask

  task automatic drop_valid_and_wait();
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  // Expected raster addresses use the plain y*320+x formula modulo 2^16.
  task automatic expect_fill(input string tag, input int x, input int y, input int ew,
                             input int eh, input int color, input int e0);
    int n;
    int a;
    n = ew * eh;
    check({tag, "_nwr"}, wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      a = ((y + i / ew) * 320 + x + i % ew) % 65536;
      check({tag, "_addr"}, wr_addr[i], a);
      check({tag, "_data"}, wr_data[i], color);
      check({tag, "_wcyc"}, wr_cyc[i], e0 + 3 + i);
    end
    check({tag, "_ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) check({tag, "_done_cyc"}, done_cyc[0], e0 + 3 + n);
    check({tag, "_nrdy"}, rdy_cyc.size(), 1);
    if (rdy_cyc.size() > 0) check({tag, "_rdy_cyc"}, rdy_cyc[0], e0 + 4 + n);
  endtask

  initial begin
    int e0;
    int eb;
    int exp_b2b[7];

    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_wr", int'(do_write), 0);
    check("rst_addr", int'(write_addr), 0);
    check("rst_data", int'(write_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic 2x2 fill
    clear_log();
    send(0, 0, 2, 2, 'hF00, e0);
    drop_valid_and_wait();
    expect_fill("basic", 0, 0, 2, 2, 'hF00, e0);

    // Zero width: SETUP then done, no writes
    clear_log();
    send(3, 4, 0, 7, 'h0F0, e0);
    drop_valid_and_wait();
    expect_fill("zero", 3, 4, 0, 7, 'h0F0, e0);

`ifdef VGA_FILL_CLIP_EN
    clear_log();
    send(318, 199, 5, 3, 'h555, e0);
    drop_valid_and_wait();
    expect_fill("clip", 318, 199, 2, 1, 'h555, e0);
`else
    clear_log();
    send(318, 0, 4, 1, 'h555, e0);
    drop_valid_and_wait();
    expect_fill("spill", 318, 0, 4, 1, 'h555, e0);

    clear_log();
    send(0, 255, 1, 1, 'h777, e0);
    drop_valid_and_wait();
    expect_fill("wrap", 0, 255, 1, 1, 'h777, e0);
`endif

    // Abort during the 4th write cycle
    clear_log();
    send(10, 5, 100, 1, 'h0AB, e0);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (cyc < e0 + 6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_nwr", wr_addr.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      check("abort_addr", wr_addr[i], 1610 + i);
    end
    check("abort_ndone", done_cyc.size(), 0);
    check("abort_nrdy", rdy_cyc.size(), 1);
    if (rdy_cyc.size() > 0) check("abort_rdy_cyc", rdy_cyc[0], e0 + 7);

    // Reset mid-fill, then a 1x1 fill
    clear_log();
    send(0, 0, 50, 2, 'hABC, e0);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (cyc < e0 + 10) @(negedge clk);
    check("midrst_pre_wr", int'(do_write), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr", int'(do_write), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    send(0, 0, 1, 1, 'h123, e0);
    drop_valid_and_wait();
    expect_fill("postrst", 0, 0, 1, 1, 'h123, e0);

    // Back-to-back with cmd_valid held high
    clear_log();
    send(0, 10, 3, 1, 'h0A0, e0);
    send(5, 10, 2, 2, 'h00B, eb);
    drop_valid_and_wait();
    check("b2b_accept_gap", eb - e0, 7);
    exp_b2b = '{3200, 3201, 3202, 3205, 3206, 3525, 3526};
    check("b2b_nwr", wr_addr.size(), 7);
    for (int i = 0; i < 7 && i < wr_addr.size(); i++) begin
      check("b2b_addr", wr_addr[i], exp_b2b[i]);
      check("b2b_data", wr_data[i], (i < 3) ? 'h0A0 : 'h00B);
    end
    check("b2b_ndone", done_cyc.size(), 2);
    if (done_cyc.size() > 0 && wr_cyc.size() > 3) begin
      check("b2b_no_overlap", int'(wr_cyc[3] > done_cyc[0]), 1);
    end

    check("busy_eq_not_ready", busy_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
